// File: rtl/exu_lsu_ctrl.sv
// AGU-to-LSU command responder: one outstanding DTCM access, load extraction, long-pipe write-back.
// Optional misaligned-access error detection is enabled by defining LSU_MISALIGN_CHECK_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 5
`endif

module exu_lsu_ctrl (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          agu_cmd_valid,
  output logic                          agu_cmd_ready,
  input  logic [`DTCM_ADDR_WIDTH-1:0]   agu_cmd_addr,
  input  logic                          agu_cmd_read,
  input  logic [`XLEN-1:0]              agu_cmd_wdata,
  input  logic [`XLEN/8-1:0]            agu_cmd_wmask,
  input  logic [`ITAG_WIDTH-1:0]        agu_cmd_itag,
  input  logic                          agu_cmd_usign,
  input  logic [1:0]                    agu_cmd_size,
  output logic                          agu_rsp_valid,
  input  logic                          agu_rsp_ready,
  output logic                          lsu_o_valid,
  input  logic                          lsu_o_ready,
  output logic [`XLEN-1:0]              lsu_o_wbck_wdat,
  output logic [`ITAG_WIDTH-1:0]        lsu_o_wbck_itag,
  output logic                          lsu_o_wbck_read,
  output logic                          lsu_o_err,
  output logic                          dtcm_cs,
  output logic                          dtcm_we,
  output logic [`XLEN/8-1:0]            dtcm_wem,
  output logic [`DTCM_ADDR_WIDTH-3:0]   dtcm_addr,
  output logic [`XLEN-1:0]              dtcm_din,
  input  logic [`XLEN-1:0]              dtcm_dout
);

  localparam int unsigned XW = `XLEN;
  localparam int unsigned AW = `DTCM_ADDR_WIDTH;
  localparam int unsigned IW = `ITAG_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, FRESH = 2'd1, HOLD = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            accept, retire, cmd_err;
  logic [XW-1:0]   hold_q;
  logic [IW-1:0]   itag_q;
  logic            read_q, usign_q, err_q;
  logic [1:0]      size_q, lane_q;
  logic [XW-1:0]   src, ext;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

`ifdef LSU_MISALIGN_CHECK_EN
  assign cmd_err = ((agu_cmd_size == 2'b01) & agu_cmd_addr[0])
                 | ((agu_cmd_size == 2'b10) & (agu_cmd_addr[1:0] != 2'b00))
                 | (agu_cmd_size == 2'b11);
`else
  assign cmd_err = 1'b0;
`endif

  assign dtcm_addr = agu_cmd_addr[AW-1:2];
  assign dtcm_din  = agu_cmd_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = FRESH;
      FRESH, HOLD: begin
        if (retire && accept) state_d = FRESH;
        else if (retire)      state_d = IDLE;
        else                  state_d = HOLD;
      end
      default:     state_d = IDLE;
    endcase
  end

  // Handshake and SRAM control; everything forced quiet while in reset
  always_comb begin
    lsu_o_valid   = 1'b0;
    retire        = 1'b0;
    agu_cmd_ready = 1'b0;
    accept        = 1'b0;
    agu_rsp_valid = 1'b0;
    dtcm_cs       = 1'b0;
    dtcm_we       = 1'b0;
    dtcm_wem      = '0;
    if (rst_n) begin
      lsu_o_valid   = (state_q != IDLE);
      retire        = lsu_o_valid & lsu_o_ready & agu_rsp_ready;
      agu_cmd_ready = (state_q == IDLE) | retire;
      accept        = agu_cmd_valid & agu_cmd_ready;
      agu_rsp_valid = lsu_o_valid & lsu_o_ready;
      dtcm_cs       = accept & ~cmd_err;
      dtcm_we       = dtcm_cs & ~agu_cmd_read;
      dtcm_wem      = dtcm_we ? agu_cmd_wmask : '0;
    end
  end

  // Command attributes and read-data hold register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q  <= '0;
      itag_q  <= '0;
      read_q  <= 1'b0;
      usign_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
    end else begin
      if (accept) begin
        itag_q  <= agu_cmd_itag;
        read_q  <= agu_cmd_read;
        usign_q <= agu_cmd_usign;
        err_q   <= cmd_err;
        size_q  <= agu_cmd_size;
        lane_q  <= agu_cmd_addr[1:0];
      end
      if (state_q == FRESH && !retire) hold_q <= dtcm_dout;
    end
  end

  // Lane select and extension of load data
  always_comb begin
    src    = (state_q == HOLD) ? hold_q : dtcm_dout;
    byte_v = src[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? src[31:16] : src[15:0];
    case (size_q)
      2'b00:   ext = usign_q ? {{(XW-8){1'b0}}, byte_v}
                             : {{(XW-8){byte_v[7]}}, byte_v};
      2'b01:   ext = usign_q ? {{(XW-16){1'b0}}, half_v}
                             : {{(XW-16){half_v[15]}}, half_v};
      default: ext = src;
    endcase
  end

  assign lsu_o_wbck_read = read_q & ~err_q;
  assign lsu_o_wbck_wdat = (lsu_o_valid & lsu_o_wbck_read) ? ext : '0;
  assign lsu_o_wbck_itag = itag_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign lsu_o_err = err_q;
`else
  assign lsu_o_err = 1'b0;
`endif

endmodule
